// File: rtl/play_sequencer_pkg.sv
// Shared definitions for the playback sequencer.
//   - Global mode codes driven by the user-interface FSM.
//   - Sequencer state encoding (plain localparams so older code can compare against them).
//   - Note width of the buzzer path.
//   - is_timed(): true for the states in which the beat prescaler runs.
package play_sequencer_pkg;

    localparam int NOTE_W = 10;

    localparam logic [1:0] FREE_MODE  = 2'b00;
    localparam logic [1:0] UART_MODE  = 2'b01;
    localparam logic [1:0] LEARN_MODE = 2'b10;
    localparam logic [1:0] PLAY_MODE  = 2'b11;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_PLAY   = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_PAUSED = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    function automatic logic is_timed(input logic [2:0] st);
        return (st == ST_PLAY) || (st == ST_GAP);
    endfunction

endpackage

// File: rtl/play_sequencer_beat_tick_gen.sv
// beat_tick_gen: beat-unit prescaler.
//   clk  : system clock
//   rst  : asynchronous, active-low reset
//   clr  : synchronous clear of the prescaler (wins over en)
//   en   : count enable; low while the sequencer is paused
//   tick : one-cycle pulse on every TICK_DIV-th enabled cycle
// tick is decoded from the registered count, so it is only used inside the
// sequencer and never reaches a module output directly.
module beat_tick_gen #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/play_sequencer.sv
// play_sequencer: song playback controller for PLAY_MODE.
// Fetches {duration, note} entries from song memory, holds each note for
// duration beat units, inserts a silent gap, and repeats until an end marker
// (duration 0) or the last address. Handles start/pause/stop/loop control.
//   clk, rst            : clock, asynchronous active-low reset
//   mode                : global mode; anything but PLAY_MODE acts as stop
//   start, pause, stop  : one-cycle control pulses (stop > pause > start)
//   loop_en             : restart from address 0 at end of song
//   mem_req, mem_addr   : read request/address, held until mem_valid
//   mem_valid, mem_data : read response {duration, note}
//   play_note           : one-hot note to the buzzer path, 0 = silence
//   busy, paused, done  : status; done pulses once when the song finishes
// Every output comes straight from a flop.
module play_sequencer
    import play_sequencer_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DUR_W     = 6,
    parameter int TICK_DIV  = 1_000_000,
    parameter int GAP_TICKS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    stop,
    input  logic                    loop_en,
    output logic                    mem_req,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic                    mem_valid,
    input  logic [DUR_W+NOTE_W-1:0] mem_data,
    output logic [NOTE_W-1:0]       play_note,
    output logic                    busy,
    output logic                    paused,
    output logic                    done
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [DUR_W-1:0]  GAP_LAST  = DUR_W'(GAP_TICKS - 1);

    logic [2:0]        state_q, state_d;
    logic [2:0]        saved_q, saved_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [DUR_W-1:0]  beat_q, beat_d;
    logic              mem_req_q, mem_req_d;
    logic [NOTE_W-1:0] play_note_q, play_note_d;
    logic              busy_q, busy_d;
    logic              paused_q, paused_d;
    logic              done_q, done_d;

    logic              beat_tick;
    logic              beat_clr;
    logic              end_of_song;

    wire [DUR_W-1:0]  entry_dur  = mem_data[DUR_W+NOTE_W-1 -: DUR_W];
    wire [NOTE_W-1:0] entry_note = mem_data[NOTE_W-1:0];
    wire              play_end   = beat_tick && (beat_q == dur_q - DUR_W'(1));
    wire              gap_end    = beat_tick && (beat_q == GAP_LAST);

    beat_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_beat_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (beat_clr),
        .en   (is_timed(state_q)),
        .tick (beat_tick)
    );

    always_comb begin
        state_d     = state_q;
        saved_d     = saved_q;
        addr_d      = addr_q;
        note_d      = note_q;
        dur_d       = dur_q;
        beat_d      = beat_tick ? beat_q + DUR_W'(1) : beat_q;
        beat_clr    = 1'b0;
        end_of_song = 1'b0;

        case (state_q)
            ST_IDLE: begin
                addr_d = '0;
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_valid) begin
                    if (entry_dur != '0) begin
                        note_d   = entry_note;
                        dur_d    = entry_dur;
                        state_d  = ST_PLAY;
                        beat_clr = 1'b1;
                    end else begin
                        end_of_song = 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (play_end) begin
                    state_d  = ST_GAP;
                    beat_clr = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_end) begin
                    // The last address ends the song instead of wrapping.
                    if (addr_q == ADDR_LAST) begin
                        end_of_song = 1'b1;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_PAUSED: begin
                if (pause) state_d = saved_q;
            end
            ST_DONE: begin
                if (start) begin
                    addr_d  = '0;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (end_of_song) begin
            if (loop_en) begin
                addr_d  = '0;
                state_d = ST_FETCH;
            end else begin
                state_d = ST_DONE;
            end
        end

        // A pause pulse parks the state the timed phase would move to next.
        // The cycle carrying the pulse still counts, so pausing on the last
        // cycle of a note saves GAP. Pausing as a gap finishes is dropped
        // because the fetch is already being launched.
        if (pause && is_timed(state_q) && is_timed(state_d)) begin
            saved_d = state_d;
            state_d = ST_PAUSED;
        end

        if (stop || (mode != PLAY_MODE)) begin
            state_d  = ST_IDLE;
            addr_d   = '0;
            beat_clr = 1'b1;
        end

        if (beat_clr) beat_d = '0;

        // The request drops for one cycle after every response, including
        // the end-marker response of a looping song.
        mem_req_d   = (state_d == ST_FETCH) && !((state_q == ST_FETCH) && mem_valid);
        play_note_d = (state_d == ST_PLAY) ? note_d : '0;
        busy_d      = (state_d != ST_IDLE) && (state_d != ST_DONE);
        paused_d    = (state_d == ST_PAUSED);
        done_d      = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            saved_q     <= ST_IDLE;
            addr_q      <= '0;
            note_q      <= '0;
            dur_q       <= '0;
            beat_q      <= '0;
            mem_req_q   <= 1'b0;
            play_note_q <= '0;
            busy_q      <= 1'b0;
            paused_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            saved_q     <= saved_d;
            addr_q      <= addr_d;
            note_q      <= note_d;
            dur_q       <= dur_d;
            beat_q      <= beat_d;
            mem_req_q   <= mem_req_d;
            play_note_q <= play_note_d;
            busy_q      <= busy_d;
            paused_q    <= paused_d;
            done_q      <= done_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = addr_q;
    assign play_note = play_note_q;
    assign busy      = busy_q;
    assign paused    = paused_q;
    assign done      = done_q;

endmodule

// File: tb/tb_play_sequencer.sv
// Directed bench for play_sequencer with a song-memory responder that
// answers mem_valid two cycles after it first sees mem_req. Expected note
// runs are queued when playback is started and popped as runs are measured.
module tb_play_sequencer;
    import play_sequencer_pkg::*;

    localparam int ADDR_W    = 3;
    localparam int DUR_W     = 6;
    localparam int TICK_DIV  = 4;
    localparam int GAP_TICKS = 1;
    localparam int GAP_CYC   = GAP_TICKS * TICK_DIV;
    localparam int MEM_LAT   = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [1:0]           mode = PLAY_MODE;
    logic                 start = 1'b0;
    logic                 pause = 1'b0;
    logic                 stop = 1'b0;
    logic                 loop_en = 1'b0;
    logic                 mem_req;
    logic [ADDR_W-1:0]    mem_addr;
    logic                 mem_valid;
    logic [DUR_W+9:0]     mem_data;
    logic [9:0]           play_note;
    logic                 busy;
    logic                 paused;
    logic                 done;

    logic [DUR_W+9:0]     song [8];
    int                   mem_age;
    int                   done_cnt = 0;
    int                   total = 0;
    int                   bad = 0;

    typedef struct {
        logic [9:0] note;
        int         len;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    play_sequencer #(
        .ADDR_W    (ADDR_W),
        .DUR_W     (DUR_W),
        .TICK_DIV  (TICK_DIV),
        .GAP_TICKS (GAP_TICKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .start     (start),
        .pause     (pause),
        .stop      (stop),
        .loop_en   (loop_en),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid),
        .mem_data  (mem_data),
        .play_note (play_note),
        .busy      (busy),
        .paused    (paused),
        .done      (done)
    );

    // Song memory: single-cycle mem_valid, MEM_LAT cycles after mem_req rises.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_valid <= 1'b0;
            mem_data  <= '0;
            mem_age   <= 0;
        end else if (mem_valid) begin
            mem_valid <= 1'b0;
            mem_age   <= 0;
        end else if (mem_req) begin
            if (mem_age == MEM_LAT - 1) begin
                mem_valid <= 1'b1;
                mem_data  <= song[mem_addr];
            end
            mem_age <= mem_age + 1;
        end else begin
            mem_age <= 0;
        end
    end

    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // 0 = start, 1 = pause, other = stop; one clock wide.
    task automatic pulse(input int which);
        case (which)
            0:       start = 1'b1;
            1:       pause = 1'b1;
            default: stop  = 1'b1;
        endcase
        @(negedge clk);
        start = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic push_exp(input logic [9:0] note, input int len);
        exp_t e;
        e.note = note;
        e.len  = len;
        sb.push_back(e);
    endtask

    task automatic push_song();
        for (int i = 0; i < 8; i++) begin
            if (song[i][DUR_W+9:10] == '0) break;
            push_exp(song[i][9:0], int'(song[i][DUR_W+9:10]) * TICK_DIV);
        end
    endtask

    task automatic load_basic();
        for (int i = 0; i < 8; i++) song[i] = '0;
        song[0] = {6'd3, 10'h001};
        song[1] = {6'd2, 10'h040};
    endtask

    // Waits (bounded) for a nonzero note, measures its run, checks it
    // against the next queued expectation. Returns on the first cycle after.
    task automatic check_note(input string tag, output int wait_c);
        logic [9:0] n;
        int         len;
        exp_t       e;
        wait_c = 0;
        while (play_note == '0 && wait_c < 200) begin
            wait_c++;
            @(negedge clk);
        end
        n   = play_note;
        len = 0;
        if (n != '0) begin
            while (play_note == n && len < 1000) begin
                len++;
                @(negedge clk);
            end
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
        end else begin
            e.note = 10'h3ff;
            e.len  = -1;
        end
        chk({tag, "_note"}, 32'(n), 32'(e.note));
        chk({tag, "_len"}, 32'(len), 32'(e.len));
    endtask

    task automatic count_gap(output int g);
        g = 0;
        while (!mem_req && play_note == '0 && g < 100) begin
            g++;
            @(negedge clk);
        end
    endtask

    task automatic wait_done(output int w);
        w = 0;
        while (!done && w < 100) begin
            w++;
            @(negedge clk);
        end
    endtask

    initial begin
        int w;
        int g;
        int n_ok;
        int dc;
        int req_seen;

        for (int i = 0; i < 8; i++) song[i] = '0;
        #2 rst = 1'b0;
        cyc(3);
        chk("reset_outputs", {play_note, mem_req, 5'(mem_addr), busy, paused, done}, 0);
        rst = 1'b1;
        cyc(2);

        // Basic playback
        load_basic();
        push_song();
        pulse(0);
        chk("b_req_after_start", mem_req, 1);
        chk("b_addr0", mem_addr, 0);
        chk("b_busy", busy, 1);
        check_note("b_n0", w);
        count_gap(g);
        chk("b_gap0", g, GAP_CYC);
        check_note("b_n1", w);
        chk("b_fetch_latency", w, MEM_LAT + 1);
        count_gap(g);
        chk("b_gap1", g, GAP_CYC);
        wait_done(w);
        chk("b_done", done, 1);
        chk("b_busy_at_done", busy, 0);
        cyc(1);
        chk("b_done_single", done, 0);

        // Pause / resume on the 5th cycle of the first note
        pulse(0);
        w = 0;
        while (play_note == '0 && w < 200) begin
            w++;
            @(negedge clk);
        end
        cyc(4);
        chk("p_5th_cycle", play_note, 10'h001);
        pulse(1);
        n_ok = 0;
        for (int i = 1; i <= 20; i++) begin
            if (paused && busy && play_note == '0) n_ok++;
            if (i == 20) pause = 1'b1;
            @(negedge clk);
        end
        pause = 1'b0;
        chk("p_hold_cycles", n_ok, 20);
        chk("p_resumed", paused, 0);
        push_exp(10'h001, 7);
        push_exp(10'h040, 8);
        check_note("p_rest", w);
        check_note("p_n1", w);
        wait_done(w);
        chk("p_done", done, 1);
        cyc(1);
        pulse(1);
        chk("p_ignored_in_done", paused, 0);

        // Loop
        loop_en = 1'b1;
        dc = done_cnt;
        push_song();
        push_exp(10'h001, 3 * TICK_DIV);
        pulse(0);
        check_note("l_n0", w);
        check_note("l_n1", w);
        check_note("l_replay", w);
        chk("l_addr_back_to_0", mem_addr, 0);
        chk("l_no_done", done_cnt - dc, 0);
        pulse(2);
        loop_en = 1'b0;
        chk("l_stop_busy", busy, 0);

        // Stop in the cycle mem_valid arrives
        pulse(0);
        w = 0;
        while (!mem_valid && w < 20) begin
            w++;
            @(negedge clk);
        end
        chk("s_valid_seen", mem_valid, 1);
        pulse(2);
        chk("s_idle", {busy, mem_req, play_note}, 0);
        cyc(6);
        chk("s_data_ignored", {busy, play_note}, 0);

        // Start outside PLAY_MODE is ignored; leaving PLAY_MODE stops
        mode = LEARN_MODE;
        pulse(0);
        chk("m_start_ignored", {busy, mem_req}, 0);
        mode = PLAY_MODE;
        pulse(0);
        w = 0;
        while (play_note == '0 && w < 200) begin
            w++;
            @(negedge clk);
        end
        cyc(3);
        chk("m_playing", play_note, 10'h001);
        mode = FREE_MODE;
        @(negedge clk);
        chk("m_mode_stop", {busy, play_note}, 0);
        mode = PLAY_MODE;
        cyc(2);

        // 8-entry song with no end marker
        for (int i = 0; i < 8; i++) begin
            song[i] = {6'd1, 10'(1 << i)};
            push_exp(10'(1 << i), TICK_DIV);
        end
        pulse(0);
        for (int i = 0; i < 8; i++) check_note($sformatf("a_n%0d", i), w);
        req_seen = 0;
        w = 0;
        while (!done && w < 50) begin
            if (mem_req) req_seen++;
            w++;
            @(negedge clk);
        end
        chk("a_done", done, 1);
        chk("a_done_after_gap", w, GAP_CYC);
        chk("a_no_fetch_past_last", req_seen, 0);
        cyc(2);

        // Asynchronous reset in the middle of the second gap
        load_basic();
        push_song();
        pulse(0);
        check_note("r_n0", w);
        check_note("r_n1", w);
        chk("r_pre_busy", busy, 1);
        chk("r_pre_addr", mem_addr, 1);
        #2 rst = 1'b0;
        #1;
        chk("r_async_outputs", {play_note, mem_req, 5'(mem_addr), busy, paused, done}, 0);
        @(negedge clk);
        rst = 1'b1;
        cyc(1);
        push_exp(10'h001, 3 * TICK_DIV);
        pulse(0);
        chk("r_restart_req", mem_req, 1);
        chk("r_restart_addr", mem_addr, 0);
        check_note("r_replay", w);
        pulse(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/play_sequencer.md
# play_sequencer

Playback controller for PLAY_MODE. It fetches song entries from the song memory, holds each note for its programmed duration, and inserts a silent gap between notes. It drives the 10-bit note that the buzzer controller selects as its database source. It also handles start/pause/stop/loop control from the user-interface FSM.

## Interface
- ADDR_W, 8, song memory address width (max 2^ADDR_W entries)
- DUR_W, 6, duration field width, in beat units
- TICK_DIV, 1_000_000, clk cycles per beat unit (10 ms at 100 MHz)
- GAP_TICKS, 2, silent beat units inserted after every note
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- mode  in  2  global mode; the sequencer runs only when mode == PLAY_MODE
- start  in  1  one-cycle pulse: begin playback from address 0
- pause  in  1  one-cycle pulse: toggle pause/resume
- stop  in  1  one-cycle pulse: abort to IDLE
- loop_en  in  1  at end of song, restart from address 0 instead of finishing
- mem_req  out  1  read request, held until mem_valid
- mem_addr  out  ADDR_W  read address, stable while mem_req is high
- mem_valid  in  1  read data valid this cycle
- mem_data  in  DUR_W+10  {duration[DUR_W-1:0], note[9:0]}; duration 0 marks end of song
- play_note  out  10  registered one-hot note to the buzzer path; 0 = silence
- busy  out  1  high in every state except IDLE and DONE
- paused  out  1  high in PAUSED
- done  out  1  one-cycle pulse when the song finishes without looping

## Operation
- States: IDLE, FETCH, PLAY, GAP, PAUSED, DONE.
- IDLE:
  - play_note=0, addr=0.
  - start with mode==PLAY_MODE -> FETCH.
- FETCH:
  - mem_req=1, mem_addr=addr.
  - On mem_valid with duration!=0: latch note and duration -> PLAY.
  - On mem_valid with duration==0 (end marker): loop_en ? (addr=0, stay FETCH, re-request next cycle) : DONE with done pulse.
- PLAY:
  - play_note=latched note for exactly duration*TICK_DIV cycles, then -> GAP.
- GAP:
  - play_note=0 for GAP_TICKS*TICK_DIV cycles, then addr+1 -> FETCH.
  - If addr == 2^ADDR_W-1, treat the end of GAP as an end marker (loop_en / DONE rules); addr never wraps silently.
- PAUSED:
  - Entered from PLAY or GAP on a pause pulse.
  - play_note=0; beat, prescaler and addr counters frozen.
  - Next pause pulse returns to the saved state. The remaining time is unchanged, and play_note restores to the latched note if the saved state was PLAY.
  - A pause pulse in IDLE, FETCH or DONE is ignored.
- DONE:
  - play_note=0.
  - start -> FETCH with addr=0; stop -> IDLE.
- stop in any state -> IDLE, addr=0, play_note=0 next cycle. An outstanding mem_req is dropped; a late mem_valid is ignored.
- mode != PLAY_MODE in any state behaves as stop.
- Priority of simultaneous pulses: stop > pause > start. start while busy is ignored.
- Counters: beat counter DUR_W bits, prescaler ceil(log2(TICK_DIV)) bits. Both clear on entry to PLAY and to GAP. No overflow is possible because the loads are bounded by the parameters.

## Timing
- Reset (rst low, async): state IDLE; play_note=0, mem_req=0, mem_addr=0, busy=0, paused=0, done=0.
- Reset mid-playback takes effect immediately, independent of clk.
- start at cycle t -> mem_req high at t+1.
- mem_valid at cycle v -> play_note = note at v+1.
- Note length:
  - play_note is nonzero for exactly duration*TICK_DIV cycles (pauses excluded).
  - It is then zero for GAP_TICKS*TICK_DIV cycles.
  - The next mem_req follows in the cycle after the gap ends.
- mem_req/mem_addr stay constant from assertion until the mem_valid cycle inclusive. mem_req drops the cycle after mem_valid.
- done: a single-cycle pulse in the cycle the state becomes DONE.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- Shared package holds:
  - mode codes: FREE_MODE=2'b00, UART_MODE=2'b01, LEARN_MODE=2'b10, PLAY_MODE=2'b11;
  - the sequencer state encoding;
  - the note width constant (10).
- One sub-module, beat_tick_gen:
  - prescaler with clear and enable inputs;
  - emits a one-cycle tick every TICK_DIV enabled cycles;
  - the enable input is low while PAUSED.
- The FSM, the beat counter and the address counter live in play_sequencer.

## Test plan
- Bench parameters: TICK_DIV=4, GAP_TICKS=1, ADDR_W=3, memory answering mem_valid 2 cycles after mem_req.
- Basic playback:
  - Stimulus: mem = {(3,0x001),(2,0x040),(0,x)}, loop_en=0, start pulse.
  - Required response: play_note=0x001 for 12 cycles, 0 for 4, 0x040 for 8, 0 for 4; then done pulse; busy=0.
- Pause/resume:
  - Stimulus: pause on the 5th cycle of note 0x001; wait 20 cycles; pause again.
  - Required response: play_note=0 and paused=1 for 20 cycles, then 0x001 for the remaining 7 cycles.
- Loop:
  - Stimulus: same song with loop_en=1.
  - Required response: after the end marker, mem_addr returns to 0 and 0x001 replays; no done pulse.
- Stop during an outstanding fetch:
  - Stimulus: stop in the cycle mem_valid arrives.
  - Required response: IDLE next cycle, play_note=0, data ignored.
- Mode change and address limit:
  - Stimulus 1: mode leaves PLAY_MODE during a note.
    - Required response: IDLE, play_note=0 next cycle.
  - Stimulus 2: an 8-entry song with no end marker.
    - Required response: done after address 7's gap.
- Async reset:
  - Stimulus: rst low mid-GAP, between clock edges.
  - Required response: all outputs 0 immediately; start after release plays from address 0.
